// File: rtl/reduce_hybrid_feeder.sv
// Packs LANES serial words into one vector per handshake, numbers vectors within a
// CYCLES-long frame and marks the last one; FLUSH closes a partial vector/frame with PAD.
module reduce_hybrid_feeder #(
    parameter int               WIDTH  = 16,
    parameter int               LANES  = 2,
    parameter int               CYCLES = 2,
    parameter logic [WIDTH-1:0] PAD    = '0
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic [WIDTH-1:0]         I,
    input  logic                     IV,
    output logic                     IR,
    input  logic                     FLUSH,
    output logic                     FACK,
    output logic [LANES*WIDTH-1:0]   O,
    output logic                     OV,
    input  logic                     OR,
    output logic                     OL
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VEC_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int BUF_N  = (LANES > 1) ? LANES - 1 : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(CYCLES - 1);

    logic [LANE_W-1:0]        lane_idx;
    logic [VEC_W-1:0]         vec_idx;
    logic [WIDTH-1:0]         fill [BUF_N];
    logic                     slot_free;
    logic                     accept;
    logic                     full;
    logic                     flush_take;
    logic                     partial;
    logic                     load;
    logic                     load_last;
    logic [LANES*WIDTH-1:0]   vec_next;

    assign slot_free  = !OV || OR;
    assign IR         = RESETN && !(lane_idx == LANE_LAST && !slot_free);
    assign accept     = IV && IR;
    assign full       = accept && (lane_idx == LANE_LAST);
    assign flush_take = RESETN && FLUSH && slot_free;
    assign FACK       = flush_take;
    assign partial    = (lane_idx != '0) || accept;
    // An empty flush still emits an all-PAD vector if a frame is open, so OL terminates it.
    assign load       = full || (flush_take && (partial || vec_idx != '0));
    assign load_last  = flush_take || (vec_idx == VEC_LAST);

    always_comb begin
        vec_next = {LANES{PAD}};
        for (int k = 0; k < LANES - 1; k++) begin
            if (LANE_W'(k) < lane_idx) begin
                vec_next[k*WIDTH +: WIDTH] = fill[k];
            end else if (LANE_W'(k) == lane_idx && accept) begin
                vec_next[k*WIDTH +: WIDTH] = I;
            end
        end
        if (full) begin
            vec_next[(LANES-1)*WIDTH +: WIDTH] = I;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            OV       <= 1'b0;
            OL       <= 1'b0;
            O        <= '0;
            lane_idx <= '0;
            vec_idx  <= '0;
            for (int k = 0; k < BUF_N; k++) begin
                fill[k] <= PAD;
            end
        end else begin
            if (load) begin
                O  <= vec_next;
                OL <= load_last;
                OV <= 1'b1;
            end else if (OR) begin
                OV <= 1'b0;
            end

            if (full || flush_take) begin
                lane_idx <= '0;
                for (int k = 0; k < BUF_N; k++) begin
                    fill[k] <= PAD;
                end
            end else if (accept) begin
                lane_idx <= lane_idx + 1'b1;
                for (int k = 0; k < BUF_N; k++) begin
                    if (LANE_W'(k) == lane_idx) begin
                        fill[k] <= I;
                    end
                end
            end

            if (load) begin
                vec_idx <= (flush_take || vec_idx == VEC_LAST) ? '0 : vec_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reduce_hybrid_feeder.sv
// Bench for reduce_hybrid_feeder: directed scenarios with literal vector expectations,
// then random traffic checked every cycle against a queue-based packing model.
module tb_reduce_hybrid_feeder;

    localparam int               WIDTH  = 16;
    localparam int               LANES  = 2;
    localparam int               CYCLES = 2;
    localparam logic [WIDTH-1:0] PAD    = '0;
    localparam int               OW     = LANES * WIDTH;

    logic            clk = 1'b0;
    logic            resetn;
    logic [WIDTH-1:0] i_w;
    logic            iv;
    logic            ir;
    logic            flush;
    logic            fack;
    logic [OW-1:0]   o;
    logic            ov;
    logic            rdy;
    logic            ol;

    reduce_hybrid_feeder #(
        .WIDTH(WIDTH), .LANES(LANES), .CYCLES(CYCLES), .PAD(PAD)
    ) dut (
        .CLK(clk), .RESETN(resetn), .I(i_w), .IV(iv), .IR(ir),
        .FLUSH(flush), .FACK(fack), .O(o), .OV(ov), .OR(rdy), .OL(ol)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: words waiting for a vector, one holding slot, frame position.
    logic [WIDTH-1:0] cur[$];
    logic [WIDTH-1:0] words[$];
    bit               hv = 0;
    logic [OW-1:0]    hd = '0;
    bit               hl = 0;
    int               vcnt = 0;
    logic [OW:0]      dlog[$];
    logic [OW:0]      mlog[$];
    bit               run = 0;
    bit               exp_ir;
    bit               exp_fack;

    initial begin
        @(posedge clk);
        run = 1;
    end

    always @(negedge clk) begin
        if (run) begin
            exp_ir   = resetn && !(cur.size() == LANES - 1 && hv && !rdy);
            exp_fack = resetn && flush && (!hv || rdy);
            chk("ir", ir, exp_ir);
            chk("fack", fack, exp_fack);
            chk("ov", ov, hv);
            if (hv) begin
                chk("o", o, hd);
                chk("ol", ol, hl);
            end
            if (resetn && ov && rdy) dlog.push_back({ol, o});

            if (!resetn) begin
                cur.delete();
                hv   = 0;
                vcnt = 0;
            end else begin
                if (hv && rdy) begin
                    mlog.push_back({hl, hd});
                    hv = 0;
                end
                words = cur;
                if (iv && exp_ir) words.push_back(i_w);
                if (words.size() == LANES || (exp_fack && (words.size() > 0 || vcnt > 0))) begin
                    for (int k = 0; k < LANES; k++)
                        hd[k*WIDTH +: WIDTH] = (k < words.size()) ? words[k] : PAD;
                    hl   = exp_fack || (vcnt == CYCLES - 1);
                    vcnt = exp_fack ? 0 : (vcnt + 1) % CYCLES;
                    hv   = 1;
                    cur.delete();
                end else begin
                    cur = words;
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] w);
        int n;
        i_w = w;
        iv  = 1'b1;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ir && n < 100);
        chk("send_ready", ir, 1'b1);
        @(posedge clk);
        #1 iv = 1'b0;
    endtask

    task automatic do_flush();
        int n;
        flush = 1'b1;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fack && n < 100);
        chk("flush_ack", fack, 1'b1);
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    logic [OW:0] exp_tab [10];

    initial begin
        exp_tab = '{33'h0_0002_0001, 33'h1_0004_0003, 33'h0_0009_0008, 33'h1_0006_0005,
                    33'h1_0000_0007, 33'h0_000b_000a, 33'h1_0000_0000, 33'h0_000d_000c,
                    33'h0_0010_000f, 33'h1_0012_0011};
        resetn = 1'b0; iv = 1'b0; i_w = '0; flush = 1'b0; rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ov", ov, 1'b0);
        chk("rst_ol", ol, 1'b0);
        chk("rst_o", o, '0);
        chk("rst_ir", ir, 1'b0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Plain streaming
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        repeat (2) @(posedge clk);

        // Backpressure: vector held, second word of next vector stalls
        #1 rdy = 1'b0;
        send(16'd8); send(16'd9); send(16'd5);
        i_w = 16'd6;
        iv  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ir", ir, 1'b0);
            chk("bp_o", o, 32'h0009_0008);
            chk("bp_ov", ov, 1'b1);
        end
        @(posedge clk);
        #1 rdy = 1'b1;
        @(negedge clk);
        chk("drain_ir", ir, 1'b1);
        @(posedge clk);
        #1 iv = 1'b0;
        repeat (2) @(posedge clk);

        // Partial flush
        #1 send(16'd7);
        do_flush();
        repeat (2) @(posedge clk);

        // Empty-fill flush terminates an open frame, then a no-op flush
        #1 send(16'd10); send(16'd11);
        repeat (2) @(posedge clk);
        #1 do_flush();
        do_flush();
        @(negedge clk);
        chk("noop_ov", ov, 1'b0);
        repeat (2) @(posedge clk);

        // Reset mid-vector and mid-frame
        #1 send(16'd12); send(16'd13); send(16'd14);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("prst_ov", ov, 1'b0);
        chk("prst_ol", ol, 1'b0);
        chk("prst_o", o, '0);
        @(posedge clk);
        #1 send(16'd15); send(16'd16); send(16'd17); send(16'd18);
        repeat (3) @(posedge clk);

        chk("dlog_n", dlog.size(), 10);
        chk("mlog_n", mlog.size(), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < dlog.size()) chk($sformatf("dut_vec%0d", k), dlog[k], exp_tab[k]);
            if (k < mlog.size()) chk($sformatf("model_vec%0d", k), mlog[k], exp_tab[k]);
        end

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            iv     = ($urandom_range(0, 3) != 0);
            i_w    = WIDTH'($urandom);
            rdy    = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 15) == 0);
            resetn = ($urandom_range(0, 1999) != 0);
        end
        @(posedge clk);
        #1;
        iv = 1'b0; flush = 1'b0; rdy = 1'b1; resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("xfer_count", dlog.size(), mlog.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
